// File: rtl/serial_cmd_encoder.sv
// rtl/serial_cmd_encoder.sv - serialises one command frame (SOF SOF SPACE LEN payload EOF EOF) into a TX byte FIFO
module serial_cmd_encoder #(
  parameter int         MAX_CMD_PAYLOAD_BYTES = 8,
  parameter logic [7:0] SOF_BYTE              = 8'hFF,
  parameter logic [7:0] SPACE_BYTE            = 8'h00,
  parameter logic [7:0] EOF_BYTE              = 8'hEE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_send,
  input  logic [7:0] cmd_payload_len,
  input  logic [7:0] cmd_payload_r0,
  input  logic [7:0] cmd_payload_r1,
  input  logic [7:0] cmd_payload_r2,
  input  logic [7:0] cmd_payload_r3,
  input  logic [7:0] cmd_payload_r4,
  input  logic [7:0] cmd_payload_r5,
  input  logic [7:0] cmd_payload_r6,
  input  logic [7:0] cmd_payload_r7,
  input  logic       fifo_full,
  input  logic       cmd_sent_received,
  output logic [7:0] data,
  output logic       data_push,
  output logic       busy,
  output logic       cmd_sent,
  output logic       cmd_encode_success,
  output logic [7:0] cmd_bytes_sent
);

  typedef enum logic [3:0] {
    S_IDLE, S_SOF1, S_SOF2, S_SPACE, S_LEN, S_PAYLOAD, S_EOF1, S_EOF2, S_DONE
  } state_t;

  localparam logic [7:0] MAX_LEN = 8'(MAX_CMD_PAYLOAD_BYTES);

  state_t     state_q, state_d;
  logic       gap_q, gap_d;
  logic       send_prev_q;
  logic [7:0] len_q, len_d;
  logic [7:0] pl_q [8];
  logic [7:0] pl_d [8];
  logic [2:0] idx_q, idx_d;
  logic [7:0] data_q, data_d;
  logic       push_q, push_d;
  logic       busy_q, busy_d;
  logic       sent_q, sent_d;
  logic       ok_q, ok_d;
  logic [7:0] bytes_q, bytes_d;

  logic       start;
  logic       last_payload;
  logic [7:0] cur_byte;

  assign start        = cmd_send & ~send_prev_q;
  assign last_payload = ({5'd0, idx_q} == (len_q - 8'd1));

  always_comb begin
    cur_byte = SOF_BYTE;
    case (state_q)
      S_SPACE:        cur_byte = SPACE_BYTE;
      S_LEN:          cur_byte = len_q;
      S_PAYLOAD:      cur_byte = pl_q[idx_q];
      S_EOF1, S_EOF2: cur_byte = EOF_BYTE;
      default:        cur_byte = SOF_BYTE;
    endcase
  end

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    len_d   = len_q;
    pl_d    = pl_q;
    idx_d   = idx_q;
    data_d  = data_q;
    push_d  = 1'b0;
    busy_d  = busy_q;
    sent_d  = sent_q;
    ok_d    = ok_q;
    bytes_d = bytes_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          len_d   = cmd_payload_len;
          pl_d[0] = cmd_payload_r0;
          pl_d[1] = cmd_payload_r1;
          pl_d[2] = cmd_payload_r2;
          pl_d[3] = cmd_payload_r3;
          pl_d[4] = cmd_payload_r4;
          pl_d[5] = cmd_payload_r5;
          pl_d[6] = cmd_payload_r6;
          pl_d[7] = cmd_payload_r7;
          idx_d   = 3'd0;
          gap_d   = 1'b0;
          bytes_d = 8'd0;
          ok_d    = 1'b0;
          busy_d  = 1'b1;
          state_d = S_SOF1;
        end
      end

      S_DONE: begin
        if (cmd_sent_received) begin
          sent_d  = 1'b0;
          state_d = S_IDLE;
        end
      end

      default: begin
        if (state_q == S_SOF1 && !gap_q && len_q > MAX_LEN) begin
          // Oversized request: report completion without touching the FIFO.
          sent_d  = 1'b1;
          busy_d  = 1'b0;
          ok_d    = 1'b0;
          state_d = S_DONE;
        end else if (!gap_q) begin
          if (!fifo_full) begin
            data_d  = cur_byte;
            push_d  = 1'b1;
            bytes_d = bytes_q + 8'd1;
            gap_d   = 1'b1;
          end
        end else begin
          gap_d = 1'b0;
          case (state_q)
            S_SOF1:  state_d = S_SOF2;
            S_SOF2:  state_d = S_SPACE;
            S_SPACE: state_d = S_LEN;
            S_LEN:   state_d = (len_q == 8'd0) ? S_EOF1 : S_PAYLOAD;
            S_PAYLOAD: begin
              if (last_payload) state_d = S_EOF1;
              else              idx_d   = idx_q + 3'd1;
            end
            S_EOF1:  state_d = S_EOF2;
            S_EOF2: begin
              sent_d  = 1'b1;
              ok_d    = 1'b1;
              busy_d  = 1'b0;
              state_d = S_DONE;
            end
            default: state_d = S_IDLE;
          endcase
        end
      end
    endcase
  end

  // Previous cmd_send resets high so a level held through reset is not an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      gap_q       <= 1'b0;
      send_prev_q <= 1'b1;
      len_q       <= 8'd0;
      for (int i = 0; i < 8; i++) pl_q[i] <= 8'd0;
      idx_q       <= 3'd0;
      data_q      <= 8'd0;
      push_q      <= 1'b0;
      busy_q      <= 1'b0;
      sent_q      <= 1'b0;
      ok_q        <= 1'b0;
      bytes_q     <= 8'd0;
    end else begin
      state_q     <= state_d;
      gap_q       <= gap_d;
      send_prev_q <= cmd_send;
      len_q       <= len_d;
      for (int i = 0; i < 8; i++) pl_q[i] <= pl_d[i];
      idx_q       <= idx_d;
      data_q      <= data_d;
      push_q      <= push_d;
      busy_q      <= busy_d;
      sent_q      <= sent_d;
      ok_q        <= ok_d;
      bytes_q     <= bytes_d;
    end
  end

  assign data               = data_q;
  assign data_push          = push_q;
  assign busy               = busy_q;
  assign cmd_sent           = sent_q;
  assign cmd_encode_success = ok_q;
  assign cmd_bytes_sent     = bytes_q;

endmodule

// File: tb/tb_serial_cmd_encoder.sv
// tb/tb_serial_cmd_encoder.sv - self-checking bench for serial_cmd_encoder
module tb_serial_cmd_encoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_send;
  logic [7:0] len;
  logic [7:0] pl [8];
  logic       fifo_full;
  logic       ack;
  logic [7:0] data;
  logic       data_push;
  logic       busy;
  logic       cmd_sent;
  logic       success;
  logic [7:0] bytes_sent;

  serial_cmd_encoder dut (
    .clk                (clk),
    .rst                (rst),
    .cmd_send           (cmd_send),
    .cmd_payload_len    (len),
    .cmd_payload_r0     (pl[0]),
    .cmd_payload_r1     (pl[1]),
    .cmd_payload_r2     (pl[2]),
    .cmd_payload_r3     (pl[3]),
    .cmd_payload_r4     (pl[4]),
    .cmd_payload_r5     (pl[5]),
    .cmd_payload_r6     (pl[6]),
    .cmd_payload_r7     (pl[7]),
    .fifo_full          (fifo_full),
    .cmd_sent_received  (ack),
    .data               (data),
    .data_push          (data_push),
    .busy               (busy),
    .cmd_sent           (cmd_sent),
    .cmd_encode_success (success),
    .cmd_bytes_sent     (bytes_sent)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         n_cmp = 0;
  int         n_fail = 0;
  logic [7:0] pq [$];
  int         pc [$];
  logic [7:0] exp_q [$];
  int         exp_t [$];
  int         viol = 0;
  bit         prev_push = 1'b0;
  bit         ffh [int];
  int         t_start;

  // Push monitor: records every pushed byte and the cycle it was visible.
  always @(negedge clk) begin
    if (data_push === 1'b1) begin
      pq.push_back(data);
      pc.push_back(cyc);
      if (prev_push) viol++;
    end
    prev_push = (data_push === 1'b1);
  end

  task automatic clear_mon();
    pq.delete();
    pc.delete();
    viol = 0;
  endtask

  // Frame image from the byte format, plus push cycles given the fifo_full history.
  task automatic make_expected(input int n);
    int t;
    exp_q.delete();
    exp_t.delete();
    if (n <= 8) begin
      exp_q.push_back(8'hFF);
      exp_q.push_back(8'hFF);
      exp_q.push_back(8'h00);
      exp_q.push_back(n[7:0]);
      for (int i = 0; i < n; i++) exp_q.push_back(pl[i]);
      exp_q.push_back(8'hEE);
      exp_q.push_back(8'hEE);
    end
    t = t_start + 1;
    foreach (exp_q[k]) begin
      while (ffh.exists(t) && ffh[t]) t++;
      exp_t.push_back(t + 1);
      t += 2;
    end
  endtask

  function automatic int expected_done();
    if (exp_t.size() == 0) return t_start + 2;
    return exp_t[exp_t.size() - 1] + 1;
  endfunction

  task automatic start_frame(input int n);
    @(negedge clk);
    len      = n[7:0];
    cmd_send = 1'b1;
    t_start  = cyc;
    @(negedge clk);
    cmd_send = 1'b0;
  endtask

  task automatic wait_sent(input int budget, output bit ok, output int when);
    ok   = 1'b0;
    when = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (cmd_sent === 1'b1) begin
        ok   = 1'b1;
        when = cyc;
        break;
      end
    end
  endtask

  task automatic do_ack();
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({data, data_push, busy, cmd_sent, success, bytes_sent} !== 20'd0) begin
      n_fail++;
      $display("FAIL reset_outputs got=%h exp=0", {data, data_push, busy, cmd_sent, success, bytes_sent});
    end
    rst = 1'b0;
    repeat (6) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || pq.size() != 0) begin
      n_fail++;
      $display("FAIL reset_held_send busy=%b pushes=%0d exp busy=0 pushes=0", busy, pq.size());
    end
    cmd_send = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic check_frame(input string name, input int when, input bit ok);
    n_cmp++;
    if (!ok || when != expected_done()) begin
      n_fail++;
      $display("FAIL %s_done_cycle got=%0d exp=%0d", name, when - t_start, expected_done() - t_start);
    end
    n_cmp++;
    if (pq.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL %s_push_count got=%0d exp=%0d", name, pq.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      n_cmp++;
      if (i >= pq.size() || pq[i] !== exp_q[i] || pc[i] != exp_t[i]) begin
        n_fail++;
        $display("FAIL %s_byte%0d got=%h@%0d exp=%h@%0d", name, i,
                 (i < pq.size()) ? pq[i] : 8'hxx, (i < pc.size()) ? pc[i] - t_start : -1,
                 exp_q[i], exp_t[i] - t_start);
      end
    end
    n_cmp++;
    if (bytes_sent !== 8'(exp_q.size()) || success !== (exp_q.size() != 0) || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_status got bytes=%0d ok=%b busy=%b exp bytes=%0d ok=%b busy=0",
               name, bytes_sent, success, busy, exp_q.size(), exp_q.size() != 0);
    end
    n_cmp++;
    if (viol != 0) begin
      n_fail++;
      $display("FAIL %s_back_to_back_push got=%0d exp=0", name, viol);
    end
    do_ack();
    n_cmp++;
    if (cmd_sent !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_ack got cmd_sent=%b exp=0", name, cmd_sent);
    end
  endtask

  task automatic test_basic();
    bit ok;
    int when;
    for (int i = 0; i < 8; i++) pl[i] = (i < 6) ? 8'(8'h11 * (i + 1)) : 8'(i);
    ffh.delete();
    clear_mon();
    start_frame(6);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_busy got=%b exp=1", busy);
    end
    make_expected(6);
    wait_sent(200, ok, when);
    check_frame("basic", when, ok);
  endtask

  task automatic test_reject();
    bit ok;
    int when;
    for (int i = 0; i < 8; i++) pl[i] = 8'($urandom);
    ffh.delete();
    clear_mon();
    start_frame(9);
    make_expected(9);
    wait_sent(50, ok, when);
    check_frame("reject", when, ok);
  endtask

  task automatic test_len0_ignore_edge();
    bit ok;
    int when;
    ffh.delete();
    clear_mon();
    start_frame(0);
    make_expected(0);
    repeat (4) @(negedge clk);
    cmd_send = 1'b1;
    wait_sent(100, ok, when);
    check_frame("len0", when, ok);
    repeat (4) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || pq.size() != 6) begin
      n_fail++;
      $display("FAIL len0_no_queued_start busy=%b pushes=%0d exp busy=0 pushes=6", busy, pq.size());
    end
    cmd_send = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_stall();
    bit ok;
    int when;
    for (int i = 0; i < 8; i++) pl[i] = 8'($urandom);
    ffh.delete();
    clear_mon();
    start_frame(5);
    while (cyc < t_start + 6) @(negedge clk);
    fifo_full = 1'b1;
    for (int c = t_start + 6; c < t_start + 26; c++) ffh[c] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_cmp++;
      if (data_push !== 1'b0 || data !== 8'h00) begin
        n_fail++;
        $display("FAIL stall_hold cyc=%0d got push=%b data=%h exp push=0 data=00",
                 cyc - t_start, data_push, data);
      end
    end
    fifo_full = 1'b0;
    make_expected(5);
    wait_sent(200, ok, when);
    check_frame("stall", when, ok);
  endtask

  task automatic test_reset_mid();
    bit ok;
    int when;
    for (int i = 0; i < 8; i++) pl[i] = 8'($urandom);
    ffh.delete();
    clear_mon();
    start_frame(4);
    while (cyc < t_start + 8) @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({data, data_push, busy, cmd_sent, success, bytes_sent} !== 20'd0) begin
      n_fail++;
      $display("FAIL midreset_outputs got=%h exp=0", {data, data_push, busy, cmd_sent, success, bytes_sent});
    end
    rst = 1'b0;
    repeat (20) @(negedge clk);
    n_cmp++;
    if (pq.size() != 4 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_abandon pushes=%0d busy=%b exp pushes=4 busy=0", pq.size(), busy);
    end
    pl[0] = 8'hAA;
    pl[1] = 8'hBB;
    clear_mon();
    start_frame(2);
    make_expected(2);
    wait_sent(100, ok, when);
    check_frame("after_reset", when, ok);
  endtask

  task automatic test_random();
    bit ok;
    int when;
    int n;
    for (int f = 0; f < 12; f++) begin
      n = $urandom_range(0, 10);
      for (int i = 0; i < 8; i++) pl[i] = 8'($urandom);
      ffh.delete();
      clear_mon();
      start_frame(n);
      ok = 1'b0;
      when = -1;
      for (int i = 0; i < 400; i++) begin
        @(negedge clk);
        if (cmd_sent === 1'b1) begin
          ok = 1'b1;
          when = cyc;
          break;
        end
        fifo_full = ($urandom_range(0, 3) == 0);
        ffh[cyc] = fifo_full;
      end
      fifo_full = 1'b0;
      make_expected(n);
      check_frame($sformatf("random%0d_len%0d", f, n), when, ok);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
  endtask

  initial begin
    rst       = 1'b1;
    cmd_send  = 1'b1;
    len       = 8'd0;
    fifo_full = 1'b0;
    ack       = 1'b0;
    for (int i = 0; i < 8; i++) pl[i] = 8'd0;
    test_reset();
    test_basic();
    test_reject();
    test_len0_ignore_edge();
    test_stall();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
